memoria_programa_cargador: RTL and testbench
============================================

Name: memoria_programa_cargador

Overview:
- Program memory that sits directly upstream of Microprocesador_Legion_H.
- Stores 256 words of 9 bits and serves i_Instrucciones from o_Direcciones_Instrucciones.
- Contains a byte-stream loader FSM that writes a program at run time and checks it with a checksum.
- Holds the processor in reset until a valid program is present, then releases it.

Parameters:
- ARRANQUE_DIRECTO, 0: if 1, reset enters RUN directly and executes the retained contents; if 0, reset enters IDLE.
- TIMEOUT_CICLOS, 1000: maximum number of cycles allowed between accepted bytes while a load is in progress.
- ANCHO_TIMEOUT, 10: width of the timeout counter; must satisfy 2^ANCHO_TIMEOUT > TIMEOUT_CICLOS.

Ports:
- i_Clk, in, 1: single clock; all state changes on the rising edge.
- i_Rst, in, 1: synchronous, active-high reset.
- i_Iniciar_Carga, in, 1: one-cycle pulse that starts, or restarts, a load.
- i_Dato_Carga, in, 8: load byte.
- i_Dato_Valido, in, 1: i_Dato_Carga is valid this cycle; at most one byte accepted per cycle.
- i_Direcciones_Instrucciones, in, 8: fetch address from the processor.
- o_Instrucciones, out, 9: instruction word to the processor.
- o_Rst_Micro, out, 1: reset to the processor; 1 means the processor is held in reset.
- o_Cargando, out, 1: 1 in states HEADER, DATA_LO, DATA_HI and CHECK.
- o_Carga_Completa, out, 1: last load passed its checksum.
- o_Error, out, 2: error code. 00 none, 01 bad high byte, 10 checksum mismatch, 11 timeout.

Behaviour:
- States: IDLE, HEADER, DATA_LO, DATA_HI, CHECK, RUN, ERROR.
- Reset:
  - State becomes RUN if ARRANQUE_DIRECTO=1, otherwise IDLE.
  - o_Rst_Micro=1 except in RUN; o_Cargando=0; o_Carga_Completa=0; o_Error=00.
  - Internal counters and checksum cleared.
  - Memory array is NOT cleared; contents are retained across reset.
- i_Iniciar_Carga=1 in any state except reset:
  - Next state HEADER; o_Rst_Micro=1 from the next cycle.
  - Clears checksum, word address, timeout counter, o_Error and o_Carga_Completa.
  - If it coincides with i_Dato_Valido, the start pulse has priority and the byte is discarded.
- HEADER:
  - On a valid byte, N = byte; N=0 means 256 words.
  - Checksum = byte; address = 0; go to DATA_LO.
- DATA_LO:
  - On a valid byte, latch it as word bits [7:0] and add it to the checksum; go to DATA_HI.
- DATA_HI:
  - On a valid byte, if bits [7:1] are not 0: o_Error=01, go to ERROR; nothing is written.
  - Otherwise write mem[address] = {byte[0], latched low byte} and add the byte to the checksum.
  - Then increment the 8-bit address. If this was word N, go to CHECK; otherwise go to DATA_LO.
- CHECK:
  - On a valid byte, compare it with the 8-bit checksum, which is the modulo-256 sum of N and all data bytes.
  - Equal: o_Carga_Completa=1, go to RUN.
  - Not equal: o_Error=10, go to ERROR.
- Timeout:
  - Counter increments every cycle without a valid byte while in HEADER through CHECK, and is cleared on every accepted byte.
  - When it reaches TIMEOUT_CICLOS: o_Error=11, go to ERROR.
- RUN:
  - o_Rst_Micro=0.
  - Bytes arriving without a start pulse are ignored.
- ERROR:
  - o_Rst_Micro=1; o_Error holds its code until the next start pulse or reset.
  - Words already written are kept.
- Read path:
  - o_Instrucciones = mem[i_Direcciones_Instrucciones], combinational, zero latency, in RUN only.
  - In every other state o_Instrucciones = 9'h000.
- Words at addresses >= N are left unchanged by a load.
- A reset in the middle of a load aborts it; words already written remain.

Test Plan:
- Load case:
  - Stimulus: i_Rst 2 cycles, then i_Iniciar_Carga, then bytes 02, 2F, 00, 24, 01, 56.
  - Required: mem[0]=0x02F, mem[1]=0x124; state RUN; o_Carga_Completa=1; o_Rst_Micro=0; address 1 reads 9'b100100100.
- Checksum case: same bytes with a final byte of 57 -> o_Error=10, o_Rst_Micro=1, o_Instrucciones=000 for every address.
- High-byte case: bytes 01, AA, 02 -> o_Error=01 on the 02 byte, and mem[0] unchanged.
- Timeout case: after the header 01, send no bytes for 1000 cycles -> o_Error=11 exactly on cycle 1000; o_Cargando=0 afterwards.
- Full memory case: header 00 with 256 words where word k = {0, k} -> address 8'hFF reads 0x0FF; the address wraps to 0 with no extra write.
- Restart case:
  - Stimulus: i_Iniciar_Carga mid-load, then a fresh 01, 2F, 00, 30.
  - Required: RUN; the earlier partial checksum is ignored; a simultaneous start pulse and valid byte discards the byte.

Source files
------------

// File: rtl/memoria_programa_cargador.sv
// 256 x 9 program memory for Microprocesador_Legion_H with a checksummed
// byte-stream loader that keeps the processor in reset until a good program is present.
module memoria_programa_cargador #(
    parameter int unsigned ARRANQUE_DIRECTO = 0,
    parameter int unsigned TIMEOUT_CICLOS   = 1000,
    parameter int unsigned ANCHO_TIMEOUT    = 10
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Iniciar_Carga,
    input  logic [7:0] i_Dato_Carga,
    input  logic       i_Dato_Valido,
    input  logic [7:0] i_Direcciones_Instrucciones,
    output logic [8:0] o_Instrucciones,
    output logic       o_Rst_Micro,
    output logic       o_Cargando,
    output logic       o_Carga_Completa,
    output logic [1:0] o_Error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } estado_e;

    localparam estado_e ESTADO_RESET = (ARRANQUE_DIRECTO != 0) ? ST_RUN : ST_IDLE;
    localparam logic [ANCHO_TIMEOUT-1:0] LIMITE = ANCHO_TIMEOUT'(TIMEOUT_CICLOS - 1);
    localparam logic [ANCHO_TIMEOUT-1:0] UNO    = ANCHO_TIMEOUT'(1);

    localparam logic [1:0] ERR_NINGUNO  = 2'b00;
    localparam logic [1:0] ERR_ALTO     = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    logic [8:0] mem [256];

    estado_e                  estado_q, estado_d;
    logic [7:0]               n_q, n_d;
    logic [7:0]               dir_q, dir_d;
    logic [7:0]               bajo_q, bajo_d;
    logic [7:0]               suma_q, suma_d;
    logic [ANCHO_TIMEOUT-1:0] cnt_q, cnt_d;
    logic [1:0]               error_q, error_d;
    logic                     completa_q, completa_d;
    logic                     escribir;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            estado_q   <= ESTADO_RESET;
            n_q        <= '0;
            dir_q      <= '0;
            bajo_q     <= '0;
            suma_q     <= '0;
            cnt_q      <= '0;
            error_q    <= ERR_NINGUNO;
            completa_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            n_q        <= n_d;
            dir_q      <= dir_d;
            bajo_q     <= bajo_d;
            suma_q     <= suma_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            completa_q <= completa_d;
        end
    end

    // No reset on the array: contents survive reset so ARRANQUE_DIRECTO can rerun them.
    always_ff @(posedge i_Clk) begin
        if (escribir) begin
            mem[dir_q] <= {i_Dato_Carga[0], bajo_q};
        end
    end

    always_comb begin
        estado_d   = estado_q;
        n_d        = n_q;
        dir_d      = dir_q;
        bajo_d     = bajo_q;
        suma_d     = suma_q;
        cnt_d      = cnt_q;
        error_d    = error_q;
        completa_d = completa_q;
        escribir   = 1'b0;

        if (i_Iniciar_Carga) begin
            estado_d   = ST_HEADER;
            suma_d     = '0;
            dir_d      = '0;
            cnt_d      = '0;
            error_d    = ERR_NINGUNO;
            completa_d = 1'b0;
        end else begin
            case (estado_q)
                ST_HEADER, ST_DATA_LO, ST_DATA_HI, ST_CHECK: begin
                    if (i_Dato_Valido) begin
                        cnt_d = '0;
                        case (estado_q)
                            ST_HEADER: begin
                                n_d      = i_Dato_Carga;
                                suma_d   = i_Dato_Carga;
                                dir_d    = '0;
                                estado_d = ST_DATA_LO;
                            end
                            ST_DATA_LO: begin
                                bajo_d   = i_Dato_Carga;
                                suma_d   = suma_q + i_Dato_Carga;
                                estado_d = ST_DATA_HI;
                            end
                            ST_DATA_HI: begin
                                if (i_Dato_Carga[7:1] != '0) begin
                                    error_d  = ERR_ALTO;
                                    estado_d = ST_ERROR;
                                end else begin
                                    escribir = ~i_Rst;
                                    suma_d   = suma_q + i_Dato_Carga;
                                    dir_d    = dir_q + 8'd1;
                                    // N = 0 encodes 256 words, so the last index is N-1 modulo 256.
                                    estado_d = (dir_q == n_q - 8'd1) ? ST_CHECK : ST_DATA_LO;
                                end
                            end
                            ST_CHECK: begin
                                if (i_Dato_Carga == suma_q) begin
                                    completa_d = 1'b1;
                                    estado_d   = ST_RUN;
                                end else begin
                                    error_d  = ERR_CHECKSUM;
                                    estado_d = ST_ERROR;
                                end
                            end
                            default: ;
                        endcase
                    end else if (cnt_q == LIMITE) begin
                        cnt_d    = '0;
                        error_d  = ERR_TIMEOUT;
                        estado_d = ST_ERROR;
                    end else begin
                        cnt_d = cnt_q + UNO;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Rst_Micro      = (estado_q != ST_RUN);
    assign o_Cargando       = (estado_q == ST_HEADER) || (estado_q == ST_DATA_LO) ||
                              (estado_q == ST_DATA_HI) || (estado_q == ST_CHECK);
    assign o_Carga_Completa = completa_q;
    assign o_Error          = error_q;
    assign o_Instrucciones  = (estado_q == ST_RUN) ? mem[i_Direcciones_Instrucciones] : 9'h000;

endmodule

// File: tb/tb_memoria_programa_cargador.sv
// Randomised and directed bench for memoria_programa_cargador; a second instance with
// ARRANQUE_DIRECTO=1 shares all stimulus so retained memory can be read back after reset.
module tb_memoria_programa_cargador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st = 1'b0;
    logic       v = 1'b0;
    logic [7:0] d = '0;
    logic [7:0] addr = '0;

    logic [8:0] instr, instr2;
    logic       rstm, carg, comp, rstm2, carg2, comp2;
    logic [1:0] err, err2;

    always #5 clk = ~clk;

    memoria_programa_cargador #(
        .ARRANQUE_DIRECTO(0),
        .TIMEOUT_CICLOS(1000),
        .ANCHO_TIMEOUT(10)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Iniciar_Carga(st),
        .i_Dato_Carga(d),
        .i_Dato_Valido(v),
        .i_Direcciones_Instrucciones(addr),
        .o_Instrucciones(instr),
        .o_Rst_Micro(rstm),
        .o_Cargando(carg),
        .o_Carga_Completa(comp),
        .o_Error(err)
    );

    memoria_programa_cargador #(
        .ARRANQUE_DIRECTO(1),
        .TIMEOUT_CICLOS(1000),
        .ANCHO_TIMEOUT(10)
    ) dut_directo (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Iniciar_Carga(st),
        .i_Dato_Carga(d),
        .i_Dato_Valido(v),
        .i_Direcciones_Instrucciones(addr),
        .o_Instrucciones(instr2),
        .o_Rst_Micro(rstm2),
        .o_Cargando(carg2),
        .o_Carga_Completa(comp2),
        .o_Error(err2)
    );

    // Reference model: the byte stream since the last start pulse is interpreted by position.
    logic [8:0] ref_mem [256];
    bit         ref_ok  [256];
    logic [7:0] flujo [$];
    bit         m_load, m_run, m_run2, m_done;
    logic [1:0] m_err;
    int         m_idle;

    int checks = 0;
    int errors = 0;

    task automatic model_byte(input logic [7:0] b);
        int idx, nw, sum;
        flujo.push_back(b);
        idx = flujo.size() - 1;
        nw  = (flujo[0] == 8'd0) ? 256 : int'(flujo[0]);
        if (idx == 0) return;
        if (idx <= 2 * nw) begin
            if ((idx - 1) % 2 == 1) begin
                if (b > 8'd1) begin
                    m_err  = 2'b01;
                    m_load = 0;
                end else begin
                    ref_mem[(idx - 1) / 2] = {b[0], flujo[idx - 1]};
                    ref_ok[(idx - 1) / 2]  = 1;
                end
            end
        end else begin
            sum = 0;
            for (int i = 0; i < idx; i++) sum += int'(flujo[i]);
            m_load = 0;
            if (sum % 256 == int'(b)) begin
                m_done = 1;
                m_run  = 1;
                m_run2 = 1;
            end else begin
                m_err = 2'b10;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit vv, input logic [7:0] dd);
        rst = r; st = s; v = vv; d = dd;
        @(negedge clk);
        rst = 0; st = 0; v = 0;
        if (r) begin
            m_load = 0; m_run = 0; m_run2 = 1; m_err = 2'b00; m_done = 0; m_idle = 0;
            flujo.delete();
        end else if (s) begin
            m_load = 1; m_run = 0; m_run2 = 0; m_err = 2'b00; m_done = 0; m_idle = 0;
            flujo.delete();
        end else if (m_load) begin
            if (vv) begin
                m_idle = 0;
                model_byte(dd);
            end else begin
                m_idle++;
                if (m_idle == 1000) begin
                    m_err  = 2'b11;
                    m_load = 0;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        cyc(0, 0, 1, b);
    endtask

    task automatic start();
        cyc(0, 1, 0, 8'h00);
    endtask

    task automatic test_reset();
        logic [9:0] stat, expv;
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        addr = 8'h00;
        #1;
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
        checks++;
        if (stat !== expv) begin
            errors++;
            $display("FAIL reset_status: got %b expected %b", stat, expv);
        end
        checks++;
        if (instr !== 9'h000) begin
            errors++;
            $display("FAIL reset_instr: got %h expected 000", instr);
        end
    endtask

    task automatic test_load();
        logic [9:0] stat, expv;
        logic [8:0] e1, e2;
        start();
        send(8'h02); send(8'h2F); send(8'h00); send(8'h24); send(8'h01); send(8'h56);
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
        checks++;
        if (stat !== expv || stat !== 10'b0_0_1_00_0_0_1_00) begin
            errors++;
            $display("FAIL load_status: got %b expected %b", stat, 10'b0_0_1_00_0_0_1_00);
        end
        addr = 8'h01;
        #1;
        checks++;
        if (instr !== 9'b100100100) begin
            errors++;
            $display("FAIL load_addr1: got %h expected 124", instr);
        end
        addr = 8'h00;
        #1;
        checks++;
        if (instr !== 9'h02F) begin
            errors++;
            $display("FAIL load_addr0: got %h expected 02f", instr);
        end
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            addr = 8'(a);
            #1;
            e1 = m_run ? ref_mem[a] : 9'h000;
            e2 = m_run2 ? ref_mem[a] : 9'h000;
            if (!m_run || ref_ok[a]) begin
                checks++;
                if (instr !== e1) begin
                    errors++;
                    $display("FAIL load_scan[%0d]: got %h expected %h", a, instr, e1);
                end
            end
            if (!m_run2 || ref_ok[a]) begin
                checks++;
                if (instr2 !== e2) begin
                    errors++;
                    $display("FAIL load_scan2[%0d]: got %h expected %h", a, instr2, e2);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_checksum();
        logic [9:0] stat, expv;
        start();
        send(8'h02); send(8'h2F); send(8'h00); send(8'h24); send(8'h01); send(8'h57);
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
        checks++;
        if (stat !== expv || err !== 2'b10) begin
            errors++;
            $display("FAIL checksum_status: got %b expected %b", stat, expv);
        end
        for (int a = 0; a < 256; a++) begin
            addr = 8'(a);
            #1;
            checks++;
            if (instr !== 9'h000 || instr2 !== 9'h000) begin
                errors++;
                $display("FAIL checksum_instr[%0d]: got %h/%h expected 000", a, instr, instr2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_high_byte();
        logic [9:0] stat, expv;
        start();
        send(8'h01); send(8'hAA); send(8'h02);
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
        checks++;
        if (stat !== expv || err !== 2'b01) begin
            errors++;
            $display("FAIL high_byte_status: got %b expected %b", stat, expv);
        end
        cyc(1, 0, 0, 8'h00);
        addr = 8'h00;
        #1;
        checks++;
        if (instr2 !== ref_mem[0] || instr2 !== 9'h02F) begin
            errors++;
            $display("FAIL high_byte_mem0: got %h expected 02f", instr2);
        end
        checks++;
        if (instr !== 9'h000 || rstm !== 1'b1) begin
            errors++;
            $display("FAIL high_byte_idle: got instr %h rst %b expected 000 1", instr, rstm);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] stat, expv;
        start();
        send(8'h01);
        for (int i = 0; i < 999; i++) cyc(0, 0, 0, 8'h00);
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
        checks++;
        if (stat !== expv || carg !== 1'b1 || err !== 2'b00) begin
            errors++;
            $display("FAIL timeout_before: got %b expected %b", stat, expv);
        end
        cyc(0, 0, 0, 8'h00);
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
        checks++;
        if (stat !== expv || err !== 2'b11 || carg !== 1'b0) begin
            errors++;
            $display("FAIL timeout_at_limit: got %b expected %b", stat, expv);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h55);
        checks++;
        if (err !== 2'b11 || carg !== 1'b0 || rstm !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: got err %b carg %b rst %b expected 11 0 1", err, carg, rstm);
        end
    endtask

    task automatic test_full();
        logic [9:0] stat, expv;
        logic [7:0] sum;
        logic [8:0] e1;
        start();
        send(8'h00);
        sum = 8'h00;
        for (int k = 0; k < 256; k++) begin
            send(8'(k));
            send(8'h00);
            sum = sum + 8'(k);
        end
        send(sum);
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
        checks++;
        if (stat !== expv || comp !== 1'b1 || rstm !== 1'b0) begin
            errors++;
            $display("FAIL full_status: got %b expected %b", stat, expv);
        end
        addr = 8'hFF;
        #1;
        checks++;
        if (instr !== 9'h0FF) begin
            errors++;
            $display("FAIL full_addr_ff: got %h expected 0ff", instr);
        end
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            addr = 8'(a);
            #1;
            e1 = m_run ? ref_mem[a] : 9'h000;
            checks++;
            if (instr !== e1) begin
                errors++;
                $display("FAIL full_scan[%0d]: got %h expected %h", a, instr, e1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        logic [9:0] stat, expv;
        start();
        send(8'h03); send(8'h11); send(8'h00);
        cyc(0, 1, 1, 8'h01);
        send(8'h01); send(8'h2F); send(8'h00); send(8'h30);
        stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
        expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
        checks++;
        if (stat !== expv || rstm !== 1'b0 || comp !== 1'b1) begin
            errors++;
            $display("FAIL restart_status: got %b expected %b", stat, expv);
        end
        addr = 8'h00;
        #1;
        checks++;
        if (instr !== 9'h02F) begin
            errors++;
            $display("FAIL restart_addr0: got %h expected 02f", instr);
        end
        addr = 8'h01;
        #1;
        checks++;
        if (instr !== 9'h001) begin
            errors++;
            $display("FAIL restart_addr1: got %h expected 001", instr);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [9:0] stat, expv;
        logic [7:0] sum, lo, hi, fin;
        logic [8:0] e1, e2;
        int nw;
        for (int it = 0; it < 6; it++) begin
            start();
            nw = $urandom_range(1, 6);
            send(8'(nw));
            sum = 8'(nw);
            for (int w = 0; w < nw && m_load; w++) begin
                repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 8'h00);
                lo = 8'($urandom);
                send(lo);
                repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 8'h00);
                hi = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
                send(hi);
                sum = sum + lo + hi;
            end
            if (m_load) begin
                fin = ($urandom_range(0, 2) == 0) ? sum + 8'($urandom_range(1, 255)) : sum;
                send(fin);
            end
            if ($urandom_range(0, 1) == 1) cyc(1, 0, 0, 8'h00);
            stat = {rstm, carg, comp, err, rstm2, carg2, comp2, err2};
            expv = {~m_run, m_load, m_done, m_err, ~m_run2, m_load, m_done, m_err};
            checks++;
            if (stat !== expv) begin
                errors++;
                $display("FAIL random_status[%0d]: got %b expected %b", it, stat, expv);
            end
            for (int j = 0; j < 16; j++) begin
                addr = (j < 8) ? 8'(j) : 8'($urandom);
                #1;
                e1 = m_run ? ref_mem[addr] : 9'h000;
                e2 = m_run2 ? ref_mem[addr] : 9'h000;
                if (!m_run || ref_ok[addr]) begin
                    checks++;
                    if (instr !== e1) begin
                        errors++;
                        $display("FAIL random_read[%0d] addr %h: got %h expected %h", it, addr, instr, e1);
                    end
                end
                if (!m_run2 || ref_ok[addr]) begin
                    checks++;
                    if (instr2 !== e2) begin
                        errors++;
                        $display("FAIL random_read2[%0d] addr %h: got %h expected %h", it, addr, instr2, e2);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            ref_mem[a] = 9'h000;
            ref_ok[a]  = 0;
        end
        m_load = 0; m_run = 0; m_run2 = 1; m_done = 0; m_err = 2'b00; m_idle = 0;
        @(negedge clk);
        test_reset();
        test_load();
        test_checksum();
        test_high_byte();
        test_timeout();
        test_full();
        test_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
